// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction path: opcodes, loader error codes and loader states.
package cpu_pkg;

    localparam int unsigned OPCODE_WIDTH_DEFAULT = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;
    localparam logic [3:0] OP_SMLT  = 4'd11;
    localparam logic [3:0] OP_LAST_LEGAL = OP_SMLT;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LEN    = 2'd1;
    localparam logic [1:0] ERR_OPCODE = 2'd2;
    localparam logic [1:0] ERR_CHKSUM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_WORD   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6,
        ST_CHK    = 3'd7
    } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs an MSB-first byte stream into DATA_WIDTH words; flags the first and last byte of each word.
module byte_word_packer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid,
    output logic                  first_byte
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             last_byte;

    assign first_byte = (cnt == '0);
    assign last_byte  = (cnt == CNT_W'(BYTES - 1));
    assign word_valid = byte_en && last_byte;

    // Shift accepted bytes in from the right; the byte counter wraps at each word boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (byte_en) begin
            word <= (word << 8) | DATA_WIDTH'(byte_in);
            cnt  <= last_byte ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed program byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OPCODE_WIDTH = OPCODE_WIDTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    loader_state_e         state, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH:0]   wl_d;
    logic                  we_d, hold_d, done_d, err_d, ready_d;
    logic [1:0]            code_d;
    logic                  byte_acc, clear, word_valid, first_byte;
    logic [15:0]           len_rx;
    logic                  bad_opcode;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign byte_acc   = rx_valid && rx_ready;
    assign len_rx     = {len_q[15:8], rx_data};
    assign bad_opcode = rx_data[7 -: OPCODE_WIDTH] > OPCODE_WIDTH'(OP_LAST_LEGAL);

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .byte_en    (byte_acc && (state == ST_WORD)),
        .byte_in    (rx_data),
        .word       (imem_wdata),
        .word_valid (word_valid),
        .first_byte (first_byte)
    );

    // Next-state and next-output logic for the load sequence.
    always_comb begin
        state_d = state;
        len_d   = len_q;
        addr_d  = imem_addr;
        wl_d    = words_loaded;
        we_d    = 1'b0;
        hold_d  = cpu_hold;
        done_d  = load_done;
        err_d   = load_err;
        code_d  = err_code;
        clear   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d  = byte_acc ? (csum_q ^ rx_data) : csum_q;
`endif
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LEN_HI;
                    len_d   = '0;
                    addr_d  = '0;
                    wl_d    = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    clear   = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (byte_acc) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_acc) begin
                    len_d = len_rx;
                    if (32'(len_rx) > DEPTH) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else if (len_rx == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (byte_acc) begin
                    if (first_byte && bad_opcode) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_OPCODE;
                    end else if (word_valid) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                wl_d = words_loaded + (ADDR_WIDTH+1)'(1);
                if (32'(imem_addr) + 32'd1 == 32'(len_q)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    addr_d  = imem_addr + ADDR_WIDTH'(1);
                    state_d = ST_WORD;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_acc) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_CHKSUM;
                    end
                end
            end
`endif
            default: ;
        endcase
        ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                  (state_d == ST_WORD)   || (state_d == ST_CHK);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            imem_addr    <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= ERR_NONE;
            rx_ready     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state        <= state_d;
            len_q        <= len_d;
            imem_addr    <= addr_d;
            words_loaded <= wl_d;
            imem_we      <= we_d;
            cpu_hold     <= hold_d;
            load_done    <= done_d;
            load_err     <= err_d;
            err_code     <= code_d;
            rx_ready     <= ready_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule
